// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg -- definitions shared by the MVU tile chain and the accumulator block.
//
// Contents:
//   accum_op_t           accumulate-op encoding on the tile-chain bus
//   *_DEF localparams    default geometry, overridable by the build macros
//                        ACCW, NDPE, NUM_ACCUM, ACCIDW, QDEPTH and WB_LMT
//   lane_lsb()           LSB position of (batch, lane) inside a packed bus
// -----------------------------------------------------------------------------
`ifndef ACCW
`define ACCW 32
`endif
`ifndef NDPE
`define NDPE 40
`endif
`ifndef NUM_ACCUM
`define NUM_ACCUM 64
`endif
`ifndef ACCIDW
`define ACCIDW 6
`endif
`ifndef QDEPTH
`define QDEPTH 16
`endif
`ifndef WB_LMT
`define WB_LMT 4
`endif

package npu_pkg;

    typedef enum logic [1:0] {
        ACC_OP_SET = 2'd0,
        ACC_OP_UPD = 2'd1,
        ACC_OP_WB  = 2'd2,
        ACC_OP_NOP = 2'd3
    } accum_op_t;

    localparam int ACCW_DEF      = `ACCW;
    localparam int NDPE_DEF      = `NDPE;
    localparam int NBATCH_DEF    = 3;
    localparam int NUM_ACCUM_DEF = `NUM_ACCUM;
    localparam int ACCIDW_DEF    = `ACCIDW;
    localparam int QDEPTH_DEF    = `QDEPTH;
    localparam int WB_LMT_DEF    = `WB_LMT;

    // Batch b, lane l sits at bits [(b*ndpe + l)*accw +: accw].
    function automatic int lane_lsb(input int b, input int l, input int ndpe, input int accw);
        return (b * ndpe + l) * accw;
    endfunction

endpackage

// File: rtl/mvu_accum_fifo.sv
// -----------------------------------------------------------------------------
// mvu_accum_fifo -- synchronous FIFO holding finished accumulator sums.
//
// Parameters: DEPTH (power of 2), WIDTH (entry width).
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointers only)
//   push        write push_data (accepted when not full, or when popping too)
//   push_data   entry to write
//   pop         remove the head entry (ignored while empty)
//   head        current head entry
//   count       number of stored entries, 0..DEPTH
//   full, empty occupancy flags
// Pointers carry one extra bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module mvu_accum_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the freed slot is the one being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mvu_accum.sv
// -----------------------------------------------------------------------------
// mvu_accum -- accumulator bank after the last MVU tile, feeding the first MFU.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_data          tile-chain sum, NBATCH*NDPE signed lanes of ACCW bits
//   i_valid         i_data / op / sel valid
//   i_accum_op      SET / UPD / WB / NOP (npu_pkg::accum_op_t)
//   i_accum_sel     accumulator entry; values >= NUM_ACCUM behave as NOP
//   o_data, o_valid output FIFO head and non-empty flag
//   i_ready         downstream pop (o_valid && i_ready)
//   o_almost_full   registered: free slots, after in-flight WBs, <= WB_LMT
//   o_overflow      sticky: a WB was dropped because the FIFO was full
//
// Build option: ACCUM_SATURATE_EN makes UPD/WB lane adds saturate instead of
// wrapping modulo 2^ACCW. SET is never affected.
//
// Pipeline: P1 registers the op and reads acc[sel]; P2 adds lane-wise, writes
// the accumulator back and stages WB sums for the FIFO. A WB seen at edge t
// reaches the FIFO at edge t+2, so o_valid rises in cycle t+3.
// -----------------------------------------------------------------------------
module mvu_accum
    import npu_pkg::*;
#(
    parameter int ACCW      = ACCW_DEF,
    parameter int NDPE      = NDPE_DEF,
    parameter int NBATCH    = NBATCH_DEF,
    parameter int NUM_ACCUM = NUM_ACCUM_DEF,
    parameter int ACCIDW    = ACCIDW_DEF,
    parameter int QDEPTH    = QDEPTH_DEF,
    parameter int WB_LMT    = WB_LMT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NBATCH*ACCW*NDPE-1:0]   i_data,
    input  logic                          i_valid,
    input  logic [1:0]                    i_accum_op,
    input  logic [ACCIDW-1:0]             i_accum_sel,
    output logic [NBATCH*ACCW*NDPE-1:0]   o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_almost_full,
    output logic                          o_overflow
);

    localparam int BUSW = NBATCH * ACCW * NDPE;
    localparam int QAW  = $clog2(QDEPTH);

    function automatic logic signed [ACCW-1:0] lane_add(
        input logic signed [ACCW-1:0] a,
        input logic signed [ACCW-1:0] b
    );
        logic signed [ACCW-1:0] s;
        s = a + b;
`ifdef ACCUM_SATURATE_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((a[ACCW-1] == b[ACCW-1]) && (s[ACCW-1] != a[ACCW-1]))
            s = a[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
`endif
        return s;
    endfunction

    logic [BUSW-1:0]   acc_mem [NUM_ACCUM];

    logic [31:0]       sel_ext;
    logic              accept;

    logic              vld_p1;
    accum_op_t         op_p1;
    logic [ACCIDW-1:0] sel_p1;
    logic [BUSW-1:0]   data_p1;
    logic [BUSW-1:0]   acc_p1;
    logic [BUSW-1:0]   sum_p1;
    logic [BUSW-1:0]   wr_p1;
    logic              wb_p1;

    logic              vld_p2;
    logic [BUSW-1:0]   data_p2;

    logic              pop;
    logic              full;
    logic              empty;
    logic [QAW:0]      count;
    logic [QAW+1:0]    used;

    assign sel_ext = 32'(i_accum_sel);
    assign accept  = i_valid
                     && (accum_op_t'(i_accum_op) != ACC_OP_NOP)
                     && (sel_ext < 32'(NUM_ACCUM));

    // ---- P1: register the op, read acc[sel] ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        op_p1   <= accum_op_t'(i_accum_op);
        sel_p1  <= i_accum_sel;
        data_p1 <= i_data;
        // The P2 op writes memory on this same edge, so a read of that entry
        // would return stale data; take the value being written instead.
        if (vld_p1 && (sel_p1 == i_accum_sel)) acc_p1 <= wr_p1;
        else                                    acc_p1 <= acc_mem[i_accum_sel];
    end

    // ---- P2: lane-wise add, accumulator write-back, WB staging ----
    always_comb begin
        sum_p1 = '0;
        for (int b = 0; b < NBATCH; b++) begin
            for (int l = 0; l < NDPE; l++) begin
                sum_p1[lane_lsb(b, l, NDPE, ACCW) +: ACCW] =
                    lane_add(acc_p1[lane_lsb(b, l, NDPE, ACCW) +: ACCW],
                             data_p1[lane_lsb(b, l, NDPE, ACCW) +: ACCW]);
            end
        end
    end

    always_comb begin
        case (op_p1)
            ACC_OP_SET: wr_p1 = data_p1;
            ACC_OP_UPD: wr_p1 = sum_p1;
            default:    wr_p1 = '0;   // WB leaves the entry cleared
        endcase
    end

    assign wb_p1 = vld_p1 && (op_p1 == ACC_OP_WB);

    always_ff @(posedge clk) begin
        if (!rst && vld_p1) acc_mem[sel_p1] <= wr_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= wb_p1;
    end

    always_ff @(posedge clk) begin
        data_p2 <= sum_p1;
    end

    // ---- FIFO push, status flags ----
    assign pop     = o_valid && i_ready;
    assign o_valid = !empty;

    mvu_accum_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (BUSW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p2),
        .push_data (data_p2),
        .pop       (pop),
        .head      (o_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Stored entries plus WBs still in P1/P2 that will land in the FIFO.
    assign used = (QAW+2)'(count) + (QAW+2)'(wb_p1) + (QAW+2)'(vld_p2);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_almost_full <= (used >= (QAW+2)'(QDEPTH - WB_LMT));
            if (vld_p2 && full && !pop) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mvu_accum.sv
// -----------------------------------------------------------------------------
// tb_mvu_accum -- self-checking bench for mvu_accum.
// A lane-array model applies each op in issue order (ops take effect one after
// another, so forwarding needs no special treatment); WB results are queued
// as the expected FIFO contents. Directed scenarios check fixed constants.
// -----------------------------------------------------------------------------
module tb_mvu_accum;
    import npu_pkg::*;

    localparam int ACCW      = ACCW_DEF;
    localparam int NDPE      = NDPE_DEF;
    localparam int NBATCH    = NBATCH_DEF;
    localparam int NUM_ACCUM = NUM_ACCUM_DEF;
    localparam int ACCIDW    = ACCIDW_DEF;
    localparam int QDEPTH    = QDEPTH_DEF;
    localparam int WB_LMT    = WB_LMT_DEF;
    localparam int NL        = NBATCH * NDPE;
    localparam int BUSW      = NL * ACCW;
    localparam longint HI    = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint LO    = -(longint'(1) <<< (ACCW - 1));

    typedef longint lanes_t [NL];

    logic              clk = 1'b0;
    logic              rst;
    logic [BUSW-1:0]   i_data;
    logic              i_valid;
    logic [1:0]        i_accum_op;
    logic [ACCIDW-1:0] i_accum_sel;
    logic [BUSW-1:0]   o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_almost_full;
    logic              o_overflow;

    always #5 clk = ~clk;

    mvu_accum #(
        .ACCW(ACCW), .NDPE(NDPE), .NBATCH(NBATCH), .NUM_ACCUM(NUM_ACCUM),
        .ACCIDW(ACCIDW), .QDEPTH(QDEPTH), .WB_LMT(WB_LMT)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .i_accum_op(i_accum_op), .i_accum_sel(i_accum_sel),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_almost_full(o_almost_full), .o_overflow(o_overflow)
    );

    int              errors = 0;
    int              checks = 0;
    longint          macc [NUM_ACCUM][NL];
    logic [BUSW-1:0] expq [$];
    logic [BUSW-1:0] got [$];
    lanes_t          stim;

    // ---------------- model helpers ----------------
    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((longint'(1) <<< ACCW) - 1);
        if (m > HI) m = m - (longint'(1) <<< ACCW);
        return m;
    endfunction

    function automatic longint model_add(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef ACCUM_SATURATE_EN
        if (s > HI) s = HI;
        else if (s < LO) s = LO;
        return s;
`else
        return wrap(s);
`endif
    endfunction

    function automatic logic [BUSW-1:0] pack(input lanes_t v);
        logic [BUSW-1:0] b;
        b = '0;
        for (int k = 0; k < NL; k++) b[k*ACCW +: ACCW] = v[k][ACCW-1:0];
        return b;
    endfunction

    function automatic int first_diff(input logic [BUSW-1:0] a, input logic [BUSW-1:0] b);
        for (int k = 0; k < NL; k++)
            if (a[k*ACCW +: ACCW] !== b[k*ACCW +: ACCW]) return k;
        return 0;
    endfunction

    function automatic logic [ACCW-1:0] lane_of(input logic [BUSW-1:0] a, input int k);
        return a[k*ACCW +: ACCW];
    endfunction

    task automatic fill_const(input longint v);
        for (int k = 0; k < NL; k++) stim[k] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NL; k++) stim[k] = wrap(longint'($urandom));
    endtask

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input int sel);
        lanes_t r;
        @(negedge clk);
        i_valid     = 1'b1;
        i_accum_op  = op;
        i_accum_sel = ACCIDW'(sel);
        i_data      = pack(stim);
        case (op)
            2'd0: for (int k = 0; k < NL; k++) macc[sel][k] = stim[k];
            2'd1: for (int k = 0; k < NL; k++) macc[sel][k] = model_add(macc[sel][k], stim[k]);
            2'd2: begin
                for (int k = 0; k < NL; k++) r[k] = model_add(macc[sel][k], stim[k]);
                if (expq.size() < QDEPTH) expq.push_back(pack(r));
                for (int k = 0; k < NL; k++) macc[sel][k] = 0;
            end
            default: ;
        endcase
        @(posedge clk);
    endtask

    // Bubbles carry a WB op with i_valid low, which must have no effect.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            i_valid    = 1'b0;
            i_accum_op = 2'd2;
            i_data     = {BUSW/32{$urandom}};
        end
    endtask

    task automatic collect(input int n);
        int guard;
        guard = 0;
        got.delete();
        while (got.size() < n && guard < 300) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_ready = 1'b1;
            if (o_valid === 1'b1) got.push_back(o_data);
            guard++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_accum_op = 2'd3;
        i_accum_sel = '0; i_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b want=0", o_almost_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", o_overflow); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b want=0", o_valid); end
        for (int s = 0; s < NUM_ACCUM; s++) begin
            fill_rand();
            issue(2'd0, s);
        end
        idle(2);
    endtask

    task automatic test_set_wb();
        logic [BUSW-1:0] w7, w0;
        i_ready = 1'b0;
        fill_const(7);  w7 = pack(stim);
        fill_const(0);  w0 = pack(stim);
        fill_const(5);  issue(2'd0, 3);
        fill_const(2);  issue(2'd2, 3);
        @(negedge clk); i_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL wb_latency_early got=%b want=0", o_valid); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL wb_latency_valid got=%b want=1", o_valid); end
        checks++; if (o_data !== w7) begin errors++;
            $display("FAIL wb_latency_data lane%0d got=%h want=%h", first_diff(o_data, w7),
                     lane_of(o_data, first_diff(o_data, w7)), lane_of(w7, first_diff(o_data, w7))); end
        fill_const(0);  issue(2'd2, 3);
        collect(2);
        checks++; if (got.size() != 2) begin errors++; $display("FAIL set_wb_count got=%0d want=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== w7) begin errors++; $display("FAIL set_wb_first lane%0d got=%h want=7", first_diff(got[0], w7), lane_of(got[0], first_diff(got[0], w7))); end
            checks++; if (got[1] !== w0) begin errors++; $display("FAIL set_wb_cleared lane%0d got=%h want=0", first_diff(got[1], w0), lane_of(got[1], first_diff(got[1], w0))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL set_wb_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_back_to_back();
        logic [BUSW-1:0] w4;
        i_ready = 1'b0;
        fill_const(4); w4 = pack(stim);
        fill_const(1);
        issue(2'd0, 0); issue(2'd1, 0); issue(2'd1, 0); issue(2'd2, 0);
        collect(1);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL b2b_count got=%0d want=1", got.size()); end
        if (got.size() == 1) begin
            checks++; if (got[0] !== w4) begin errors++; $display("FAIL b2b_sum lane%0d got=%h want=4", first_diff(got[0], w4), lane_of(got[0], first_diff(got[0], w4))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_random_ops();
        int op, n;
        i_ready = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else begin
                op = int'($urandom_range(0, 3));
                if (op == 2 && expq.size() >= QDEPTH - 1) op = 1;
                fill_rand();
                issue(2'(op), int'($urandom_range(0, 7)));
            end
        end
        n = expq.size();
        collect(n);
        checks++; if (got.size() != n) begin errors++; $display("FAIL random_count got=%0d want=%0d", got.size(), n); end
        for (int i = 0; i < got.size() && i < n; i++) begin
            checks++;
            if (got[i] !== expq[i]) begin errors++;
                $display("FAIL random_item%0d lane%0d got=%h want=%h", i, first_diff(got[i], expq[i]),
                         lane_of(got[i], first_diff(got[i], expq[i])), lane_of(expq[i], first_diff(got[i], expq[i]))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL random_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_saturate();
        logic [BUSW-1:0] wpos, wneg;
`ifdef ACCUM_SATURATE_EN
        fill_const(HI); wpos = pack(stim);
        fill_const(LO); wneg = pack(stim);
`else
        fill_const(LO); wpos = pack(stim);
        fill_const(HI); wneg = pack(stim);
`endif
        i_ready = 1'b0;
        fill_const(HI); issue(2'd0, 40);
        fill_const(1);  issue(2'd1, 40);
        fill_const(0);  issue(2'd2, 40);
        fill_const(LO); issue(2'd0, 41);
        fill_const(-1); issue(2'd1, 41);
        fill_const(0);  issue(2'd2, 41);
        collect(2);
        checks++; if (got.size() != 2) begin errors++; $display("FAIL sat_count got=%0d want=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== wpos) begin errors++; $display("FAIL sat_pos lane%0d got=%h want=%h", first_diff(got[0], wpos), lane_of(got[0], first_diff(got[0], wpos)), lane_of(wpos, 0)); end
            checks++; if (got[1] !== wneg) begin errors++; $display("FAIL sat_neg lane%0d got=%h want=%h", first_diff(got[1], wneg), lane_of(got[1], first_diff(got[1], wneg)), lane_of(wneg, 0)); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sat_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_overflow();
        i_ready = 1'b0;
        for (int k = 1; k <= QDEPTH; k++) begin
            fill_rand();
            issue(2'd2, k - 1);
            idle(3);
            checks++;
            if (o_almost_full !== 1'((QDEPTH - k) <= WB_LMT)) begin errors++;
                $display("FAIL afull_at_%0d got=%b want=%b", k, o_almost_full, 1'((QDEPTH - k) <= WB_LMT)); end
            checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early_%0d got=%b want=0", k, o_overflow); end
        end
        fill_rand();
        issue(2'd2, QDEPTH);
        idle(3);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", o_overflow); end
        collect(QDEPTH);
        checks++; if (got.size() != QDEPTH) begin errors++; $display("FAIL ovf_drain_count got=%0d want=%0d", got.size(), QDEPTH); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin errors++;
                $display("FAIL ovf_item%0d lane%0d got=%h want=%h", i, first_diff(got[i], expq[i]),
                         lane_of(got[i], first_diff(got[i], expq[i])), lane_of(expq[i], first_diff(got[i], expq[i]))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_tail got=%b want=0", o_valid); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", o_overflow); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_full_pop();
        logic [BUSW-1:0] head_exp;
        @(negedge clk); rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        expq.delete();
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf_cleared got=%b want=0", o_overflow); end
        for (int k = 0; k < QDEPTH; k++) begin
            fill_rand();
            issue(2'd2, k);
        end
        idle(4);
        checks++; if (o_almost_full !== 1'b1) begin errors++; $display("FAIL fp_afull got=%b want=1", o_almost_full); end
        head_exp = expq.pop_front();
        fill_rand();
        issue(2'd2, 20);
        @(negedge clk); i_valid = 1'b0;
        @(negedge clk); i_ready = 1'b1;
        checks++; if (o_data !== head_exp) begin errors++; $display("FAIL fp_head lane%0d got=%h want=%h", first_diff(o_data, head_exp), lane_of(o_data, first_diff(o_data, head_exp)), lane_of(head_exp, first_diff(o_data, head_exp))); end
        @(negedge clk); i_ready = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fp_no_ovf got=%b want=0", o_overflow); end
        idle(2);
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fp_no_ovf_late got=%b want=0", o_overflow); end
        collect(QDEPTH);
        checks++; if (got.size() != QDEPTH) begin errors++; $display("FAIL fp_drain_count got=%0d want=%0d", got.size(), QDEPTH); end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin errors++;
                $display("FAIL fp_item%0d lane%0d got=%h want=%h", i, first_diff(got[i], expq[i]),
                         lane_of(got[i], first_diff(got[i], expq[i])), lane_of(expq[i], first_diff(got[i], expq[i]))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fp_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    task automatic test_rst_mid();
        logic [BUSW-1:0] w6;
        i_ready = 1'b0;
        fill_rand(); issue(2'd2, 50);
        fill_rand(); issue(2'd2, 51);
        idle(4);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got=%b want=1", o_valid); end
        fill_rand(); issue(2'd2, 60);
        fill_rand(); issue(2'd2, 61);
        fill_rand(); issue(2'd2, 62);
        @(negedge clk); rst = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b want=0", o_valid); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf got=%b want=0", o_overflow); end
        rst = 1'b0;
        expq.delete();
        idle(6);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_stale got=%b want=0", o_valid); end
        checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL rm_afull got=%b want=0", o_almost_full); end
        fill_const(6);  w6 = pack(stim);
        fill_const(9);  issue(2'd0, 50);
        fill_const(-3); issue(2'd2, 50);
        collect(1);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rm_after_count got=%0d want=1", got.size()); end
        if (got.size() == 1) begin
            checks++; if (got[0] !== w6) begin errors++; $display("FAIL rm_after_data lane%0d got=%h want=6", first_diff(got[0], w6), lane_of(got[0], first_diff(got[0], w6))); end
        end
        repeat (4) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_tail got=%b want=0", o_valid); end
        i_ready = 1'b0;
        expq.delete();
    endtask

    initial begin
        test_reset();
        test_set_wb();
        test_back_to_back();
        test_random_ops();
        test_saturate();
        test_overflow();
        test_full_pop();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvu_accum.md
Name: mvu_accum

Overview:
- Consumes the reduced output of the last MVU tile in the chain: data, valid, accumulate op and accumulator select.
- Keeps a bank of per-lane accumulators indexed by accumulator select.
- On write-back (WB), pushes the finished sum into an output FIFO, which the downstream MFU pipeline pops with a valid/ready handshake.
- Sits between the MVU tile chain and the first MFU.

Parameters:
- ACCW, `ACCW (32): accumulator/lane width, signed.
- NDPE, `NDPE (40): lanes per batch.
- NBATCH, 3: batches carried in parallel on the chain bus.
- NUM_ACCUM, `NUM_ACCUM (64): accumulator entries.
- ACCIDW, `ACCIDW (6): width of accumulator select.
- QDEPTH, `QDEPTH (16): output FIFO depth, power of 2.
- WB_LMT, `WB_LMT (4): almost-full slack, in free slots.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_data  in  NBATCH*ACCW*NDPE  tile-chain sum; batch b, lane l occupies bits [(b*NDPE+l)*ACCW +: ACCW].
- i_valid  in  1  i_data and ops valid.
- i_accum_op  in  2  0=SET, 1=UPD, 2=WB, 3=NOP.
- i_accum_sel  in  ACCIDW  accumulator entry.
- o_data  out  NBATCH*ACCW*NDPE  FIFO head.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  downstream pop.
- o_almost_full  out  1  free FIFO slots <= WB_LMT; upstream instruction issue stalls on it.
- o_overflow  out  1  sticky error.

Behaviour:
- Reset: all FIFO pointers = 0, all pipeline valids = 0; o_valid=0, o_almost_full=0, o_overflow=0.
- Accumulator contents are not reset; SET defines them.
- Pipeline stage P1: register the inputs and read acc[sel].
- Pipeline stage P2: compute sum = acc[sel] + in, lane-wise with no cross-lane carry; then per op:
  - SET: acc[sel] <= in.
  - UPD: acc[sel] <= sum.
  - WB: push sum into the FIFO and clear acc[sel] to 0.
  - NOP, or i_valid=0: no state change.
- Hazard forwarding: if the P2 entry writes the same sel that P1 is reading, P1 uses the P2 result instead of the memory read. Back-to-back UPDs to one entry must sum correctly with zero bubbles.
- Latency: a WB accepted at cycle t gives o_valid=1 with the data at cycle t+3, if the FIFO was empty.
- Arithmetic wraps modulo 2^ACCW unless ACCUM_SATURATE_EN is defined.
- FIFO handshake: a pop occurs when o_valid && i_ready.
- Simultaneous push and pop while full: allowed; count is unchanged and not an overflow.
- Push while full without a pop: the data is dropped, o_overflow sets and holds until rst.
- o_almost_full is registered and reflects the count including the in-flight P1/P2 WBs.
- Pointers wrap modulo QDEPTH; full/empty are distinguished by an extra pointer bit.
- i_ready while empty: no effect.
- rst mid-operation: in-flight ops are discarded and the FIFO empties the next cycle.
- An out-of-range i_accum_sel (>= NUM_ACCUM) is treated as NOP.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: SET is unchanged. Each UPD/WB lane add saturates to [-2^(ACCW-1), 2^(ACCW-1)-1], detected from the operand and result signs.
- Undefined: plain two's-complement wrap, with no added logic.

Decomposition:
- Shared package npu_pkg holds:
  - the accum_op_t enum ACC_OP_SET/UPD/WB/NOP, so the tile and this block share the encodings;
  - the lane-slice helper constants.
- One sub-module: mvu_accum_fifo, a synchronous FIFO with QDEPTH/width parameters that exposes its count, used for o_almost_full.
- Accumulator storage: inferred dual-port memory, NUM_ACCUM x NBATCH*ACCW*NDPE.

Test Plan:
- SET sel=3 with all lanes 5, then WB sel=3 with lanes 2 -> o_data all lanes 7 at t+3. A following WB sel=3 with lanes 0 -> lanes 0 (the entry was cleared).
- Back-to-back SET 1, UPD 1, UPD 1, WB 1, all to sel=0, every cycle -> single output of 4 per lane (checks forwarding).
- i_ready=0, issue 16 WBs: o_almost_full rises when 4 slots remain. A 17th WB gives o_overflow=1, and the 16 entries drain in order.
- Full FIFO, WB and i_ready=1 in the same cycle -> no overflow; the new entry is last out.
- UPD of 0x7FFFFFFF + 1: with ACCUM_SATURATE_EN -> 0x7FFFFFFF; without -> 0x80000000. Same check for the negative bound.
- Pulse rst with 3 WBs in flight and the FIFO holding 2 -> o_valid=0 the next cycle, o_overflow=0, no stale outputs afterwards.
